alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one 8-bit ALU instance (16-bit result, carry/zero flags, active-high en clears operand regs)
//  between two requesters. Round-robin arbitration, one operation in flight, valid/ready on both sides.
//  Drives the ALU operand/select/en pins, holds them stable for the ALU's registered latency, captures
//  result+flags, returns them tagged with requester id. Traps divide-by-zero without issuing it.
// PARAMETERS
//  ALU_LAT  2  clk cycles from operands presented (en=0) until alu_y/alu_carry/alu_zero valid
//  CNT_W    16 width of completed-operation counter
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   2   per-requester request valid ([0]=req0, [1]=req1)
//  req_ready    out  2   per-requester accept; at most one bit high per cycle
//  req0_a/req0_b in  8   requester 0 operands;  req0_op in 4  requester 0 ALU select
//  req1_a/req1_b in  8   requester 1 operands;  req1_op in 4  requester 1 ALU select
//  alu_en       out  1   to ALU en; 1 = ALU operand regs held cleared
//  alu_a/alu_b  out  8   to ALU operands;  alu_s out 4  to ALU select
//  alu_y        in   16  ALU result;  alu_carry in 1;  alu_zero in 1
//  rsp_valid    out  1   response valid
//  rsp_ready    in   1   response consumer ready
//  rsp_id       out  1   requester owning the response
//  rsp_y        out  16  result;  rsp_carry/rsp_zero out 1  flags;  rsp_err out 1  divide-by-zero trap
//  busy         out  1   high in any state except IDLE
//  ops_done     out  CNT_W  count of completed responses (handshakes), wraps to 0
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, last_grant=1 (req0 wins first tie), req_ready=0, alu_en=1,
//   alu_a/alu_b/alu_s=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_carry/zero/err=0, busy=0, ops_done=0.
//  FSM: IDLE -> EXEC -> CAPT -> RESP -> IDLE; IDLE -> RESP directly for divide-by-zero.
//  IDLE: alu_en=1. req_ready is combinational: grant = sole valid requester, or on both valid the one
//   != last_grant. Handshake (valid&ready) at edge T latches a/b/op/id, updates last_grant.
//   Nothing latched if no valid. If latched op==5 and b==0 -> RESP with rsp_y=16'hFFFF,
//   rsp_carry=0, rsp_zero=0, rsp_err=1; ALU not driven (alu_en stays 1).
//  EXEC: ALU_LAT cycles (T+1..T+ALU_LAT). alu_en=0, alu_a/b/s = latched values, held constant.
//  CAPT: one cycle (T+ALU_LAT+1), pins still held; at its end latch alu_y/carry/zero into rsp_*,
//   rsp_err=0.
//  RESP: rsp_valid=1 from T+ALU_LAT+2 (T+1 for trap). alu_en=1, alu_a/b/s keep last values.
//   rsp_* stable while rsp_valid & !rsp_ready. On rsp_valid&rsp_ready: ops_done+=1 (wrap), next=IDLE.
//  No new request accepted outside IDLE; requester holds valid/data until its ready.
//  Response-to-IDLE-to-accept: minimum gap one cycle (IDLE cycle after RESP handshake).
//  A requester dropping valid before ready: no grant, no effect on last_grant.
//  rst_n low mid-operation: immediate return to reset values; in-flight op discarded, no response.
//  busy = (state != IDLE). Only alu_y bits produced by ALU used; no width extension by this block.
// TESTING
//  1 req0 only: a=8'd200,b=8'd100,op=0 -> req_ready=2'b01 at T; rsp_valid at T+4 (ALU_LAT=2),
//    rsp_y=16'h002C, rsp_carry=0 (ALU carry from 8-bit-truncated result), rsp_id=0.
//  2 both valid after reset: req0 mul 12*11, req1 xor 8'hF0^8'hF0 -> req0 first (rsp_y=16'd132),
//    then req1 (rsp_y=0, rsp_zero=1, rsp_id=1); with both held, grants alternate 0,1,0,1.
//  3 req1 op=5, a=8'd9, b=0 -> rsp_valid at T+1, rsp_y=16'hFFFF, rsp_err=1, alu_en never low.
//  4 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_* stable, req_ready=0, ops_done unchanged;
//    release -> ops_done+1, IDLE next cycle.
//  5 rst_n asserted in EXEC -> all outputs at reset values same cycle; no response emitted after.
//  6 ops_done preset-by-traffic to 16'hFFFF, one more response -> ops_done=0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered 8-bit ALU between two valid/ready requesters
// using round-robin arbitration, one operation in flight, divide-by-zero trapped before issue.
module alu_req_arbiter #(
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [3:0]       req0_op,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [3:0]       req1_op,
  output logic             alu_en,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_s,
  input  logic [15:0]      alu_y,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_y,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int         LAT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [3:0] OP_DIV = 4'd5;

  logic [1:0]       state;
  logic             last_grant;
  logic [LAT_W-1:0] lat_cnt;
  logic [1:0]       grant;
  logic             accept;
  logic             sel_id;
  logic [7:0]       sel_a;
  logic [7:0]       sel_b;
  logic [3:0]       sel_op;
  logic             div_zero;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = ((state == IDLE) && rst_n) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel_id    = req_ready[1];
  assign sel_a     = sel_id ? req1_a  : req0_a;
  assign sel_b     = sel_id ? req1_b  : req0_b;
  assign sel_op    = sel_id ? req1_op : req0_op;
  assign div_zero  = (sel_op == OP_DIV) && (sel_b == 8'd0);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_cnt    <= '0;
      alu_en     <= 1'b1;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      alu_s      <= 4'd0;
      rsp_id     <= 1'b0;
      rsp_y      <= 16'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= sel_id;
            rsp_id     <= sel_id;
            // Divide-by-zero never reaches the ALU; the trap result is answered directly.
            if (div_zero) begin
              state     <= RESP;
              rsp_y     <= 16'hFFFF;
              rsp_carry <= 1'b0;
              rsp_zero  <= 1'b0;
              rsp_err   <= 1'b1;
            end else begin
              state   <= EXEC;
              alu_en  <= 1'b0;
              alu_a   <= sel_a;
              alu_b   <= sel_b;
              alu_s   <= sel_op;
              lat_cnt <= '0;
            end
          end
        end
        EXEC: begin
          if (lat_cnt == LAT_W'(ALU_LAT - 1)) begin
            state <= CAPT;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        CAPT: begin
          rsp_y     <= alu_y;
          rsp_carry <= alu_carry;
          rsp_zero  <= alu_zero;
          rsp_err   <= 1'b0;
          alu_en    <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            ops_done <= ops_done + 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: directed scenarios then random two-requester traffic, checked
// by a scoreboard fed from a transaction-level model of the arbiter and a behavioural ALU.
module tb_alu_req_arbiter;

  localparam int                ALU_LAT = 2;
  localparam int                CNT_W   = 6;
  localparam logic [CNT_W-1:0]  OPS_MAX = '1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [7:0]       req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_op, req1_op;
  logic             alu_en;
  logic [7:0]       alu_a, alu_b;
  logic [3:0]       alu_s;
  logic [15:0]      alu_y = 16'd0;
  logic             alu_carry = 1'b0;
  logic             alu_zero = 1'b0;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [15:0]      rsp_y;
  logic             rsp_carry, rsp_zero, rsp_err, busy;
  logic [CNT_W-1:0] ops_done;

  always #5 clk = ~clk;

  alu_req_arbiter #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    logic [7:0] t;
    case (op)
      4'd0:    begin t = a + b; return {8'h00, t}; end
      4'd1:    begin t = a - b; return {8'h00, t}; end
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      4'd4:    return {8'h00, a | b};
      4'd5:    return (b == 8'd0) ? 16'h0000 : {8'h00, a / b};
      4'd6:    return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural two-stage ALU: operand regs (cleared while en=1), then registered result.
  logic [7:0]  alu_ra = 8'd0, alu_rb = 8'd0;
  logic [3:0]  alu_rs = 4'd0;
  logic [15:0] alu_next;
  assign alu_next = alu_fn(alu_ra, alu_rb, alu_rs);
  always @(posedge clk) begin
    alu_ra    <= alu_en ? 8'd0 : alu_a;
    alu_rb    <= alu_en ? 8'd0 : alu_b;
    alu_rs    <= alu_en ? 4'd0 : alu_s;
    alu_y     <= alu_next;
    alu_carry <= alu_next[8];
    alu_zero  <= (alu_next == 16'd0);
  end

  typedef struct packed {
    logic        id;
    logic [15:0] y;
    logic        carry;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic             m_idle = 1'b1, m_pend = 1'b0, m_trap = 1'b0, m_last = 1'b1;
  int               m_wait = 0;
  logic [CNT_W-1:0] m_ops = '0;
  logic [7:0]       m_a = 8'd0, m_b = 8'd0;
  logic [3:0]       m_op = 4'd0;

  function automatic rsp_t expect_rsp(input logic id, input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] op);
    rsp_t        r;
    logic [15:0] y;
    r.id = id;
    if (op == 4'd5 && b == 8'd0) begin
      r.y = 16'hFFFF; r.carry = 1'b0; r.zero = 1'b0; r.err = 1'b1;
    end else begin
      y = alu_fn(a, b, op);
      r.y = y; r.carry = y[8]; r.zero = (y == 16'd0); r.err = 1'b0;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle monitor: predicts grant, busy, ALU pin activity and response timing from the
  // transaction rules, and pops the scoreboard whenever the DUT presents a response.
  task automatic monitor_loop();
    logic [1:0] exp_ready, hs;
    logic       exp_en, exp_rv, id;
    rsp_t       r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_idle = 1'b1; m_pend = 1'b0; m_trap = 1'b0; m_last = 1'b1; m_wait = 0; m_ops = '0;
        sb.delete();
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_alu_en", 32'(alu_en), 32'd1);
        checkOutput("rst_ops_done", 32'(ops_done), 32'd0);
      end else begin
        exp_ready = 2'b00;
        if (m_idle) begin
          if (req_valid == 2'b01)      exp_ready = 2'b01;
          else if (req_valid == 2'b10) exp_ready = 2'b10;
          else if (req_valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
        end
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("busy", 32'(busy), 32'(!m_idle));
        checkOutput("ops_done", 32'(ops_done), 32'(m_ops));
        exp_en = !(m_pend && !m_trap && m_wait > 0);
        checkOutput("alu_en", 32'(alu_en), 32'(exp_en));
        if (!exp_en) begin
          checkOutput("alu_a", 32'(alu_a), 32'(m_a));
          checkOutput("alu_b", 32'(alu_b), 32'(m_b));
          checkOutput("alu_s", 32'(alu_s), 32'(m_op));
        end
        exp_rv = m_pend && (m_wait == 0);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (rsp_valid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL rsp_unexpected: response id=%0d y=0x%0h with nothing outstanding",
                     rsp_id, rsp_y);
          end else begin
            r = sb[0];
            checkOutput("rsp_id", 32'(rsp_id), 32'(r.id));
            checkOutput("rsp_y", 32'(rsp_y), 32'(r.y));
            checkOutput("rsp_carry", 32'(rsp_carry), 32'(r.carry));
            checkOutput("rsp_zero", 32'(rsp_zero), 32'(r.zero));
            checkOutput("rsp_err", 32'(rsp_err), 32'(r.err));
            if (rsp_ready) void'(sb.pop_front());
          end
        end
        if (m_idle) begin
          hs = req_valid & exp_ready;
          if (hs != 2'b00) begin
            id     = hs[1];
            m_a    = id ? req1_a  : req0_a;
            m_b    = id ? req1_b  : req0_b;
            m_op   = id ? req1_op : req0_op;
            m_trap = (m_op == 4'd5) && (m_b == 8'd0);
            sb.push_back(expect_rsp(id, m_a, m_b, m_op));
            m_last = id;
            m_idle = 1'b0;
            m_pend = 1'b1;
            m_wait = m_trap ? 0 : ALU_LAT + 1;
          end
        end else if (m_pend) begin
          if (m_wait > 0) m_wait--;
          else if (rsp_ready) begin
            m_pend = 1'b0;
            m_idle = 1'b1;
            m_ops  = m_ops + 1'b1;
          end
        end
      end
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    if (i == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_a = a; req1_b = b; req1_op = op; end
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_accept(input int i, output logic [1:0] rdy);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(req_valid[i] && req_ready[i]) && n < 50);
    rdy = req_ready;
    checks++;
    if (!(req_valid[i] && req_ready[i])) begin
      errors++;
      $display("[TB] FAIL accept_timeout: requester %0d not granted within 50 cycles", i);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("[TB] FAIL rsp_timeout: no response within 50 cycles");
    end
  endtask

  task automatic applyStimulus(input int cycles);
    logic [1:0] hs;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0)
            set_req(i, 8'($urandom), ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom),
                    4'($urandom_range(9)));
        end else if (!hs[i] && $urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] rdy;
    int         n;
    int         guard;
    rst_n = 1'b0;
    req_valid = 2'b00;
    req0_a = 8'd0; req0_b = 8'd0; req0_op = 4'd0;
    req1_a = 8'd0; req1_b = 8'd0; req1_op = 4'd0;
    rsp_ready = 1'b1;
    fork
      monitor_loop();
      begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single requester add");
        set_req(0, 8'd200, 8'd100, 4'd0);
        wait_accept(0, rdy);
        checkOutput("t1_ready", 32'(rdy), 32'h1);
        wait_rsp(n);
        checkOutput("t1_latency", 32'(n), 32'd4);
        checkOutput("t1_y", 32'(rsp_y), 32'h002C);
        checkOutput("t1_carry", 32'(rsp_carry), 32'd0);
        checkOutput("t1_id", 32'(rsp_id), 32'd0);

        $display("[TB] both requesters held, grants alternate");
        @(posedge clk);
        do_reset();
        set_req(0, 8'd12, 8'd11, 4'd2);
        set_req(1, 8'hF0, 8'hF0, 4'd6);
        for (int k = 0; k < 4; k++) begin
          n = 0;
          do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 50);
          checkOutput("t2_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
          wait_rsp(n);
          checkOutput("t2_y", 32'(rsp_y), (k % 2 == 0) ? 32'd132 : 32'd0);
          checkOutput("t2_id", 32'(rsp_id), 32'(k % 2));
          checkOutput("t2_zero", 32'(rsp_zero), 32'(k % 2));
        end
        @(posedge clk);
        #1 req_valid = 2'b00;

        $display("[TB] divide-by-zero trap");
        set_req(1, 8'd9, 8'd0, 4'd5);
        wait_accept(1, rdy);
        wait_rsp(n);
        checkOutput("t3_latency", 32'(n), 32'd1);
        checkOutput("t3_y", 32'(rsp_y), 32'hFFFF);
        checkOutput("t3_err", 32'(rsp_err), 32'd1);
        checkOutput("t3_alu_en", 32'(alu_en), 32'd1);
        checkOutput("t3_id", 32'(rsp_id), 32'd1);
        @(posedge clk);

        $display("[TB] response backpressure");
        #1 rsp_ready = 1'b0;
        set_req(0, 8'hAA, 8'h0F, 4'd3);
        set_req(1, 8'h33, 8'h11, 4'd4);
        wait_accept(0, rdy);
        wait_rsp(n);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checkOutput("t4_valid", 32'(rsp_valid), 32'd1);
          checkOutput("t4_y", 32'(rsp_y), 32'h000A);
          checkOutput("t4_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_idle", 32'(busy), 32'd0);
        checkOutput("t4_next_grant", 32'(req_ready), 32'h2);
        wait_accept(1, rdy);
        wait_rsp(n);
        checkOutput("t4_or_y", 32'(rsp_y), 32'h0033);
        @(posedge clk);

        $display("[TB] reset during execution");
        set_req(0, 8'd7, 8'd9, 4'd2);
        wait_accept(0, rdy);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_alu_en", 32'(alu_en), 32'd1);
        checkOutput("t5_alu_a", 32'(alu_a), 32'd0);
        checkOutput("t5_alu_s", 32'(alu_s), 32'd0);
        checkOutput("t5_ops_done", 32'(ops_done), 32'd0);
        checkOutput("t5_rsp_y", 32'(rsp_y), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) begin
          @(negedge clk);
          checkOutput("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end

        $display("[TB] completed-operation counter wrap");
        guard = 0;
        while (m_ops != OPS_MAX && guard < 200) begin
          @(posedge clk);
          #1 set_req(0, 8'($urandom), 8'd0, 4'd5);
          wait_accept(0, rdy);
          wait_rsp(n);
          guard++;
        end
        @(posedge clk);
        #1 set_req(0, 8'd1, 8'd0, 4'd5);
        wait_accept(0, rdy);
        wait_rsp(n);
        checkOutput("t6_max", 32'(ops_done), 32'(OPS_MAX));
        @(negedge clk);
        checkOutput("t6_wrap", 32'(ops_done), 32'd0);

        $display("[TB] random traffic");
        applyStimulus(3000);
        @(posedge clk);
        #1 req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        checkOutput("drain_scoreboard", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    join
  end

endmodule
